cdc_handshake_tx: RTL and testbench

//  Source-side controller for a multi-bit clock-domain crossing using a 4-phase req/ack handshake.

---
 rtl/cdc_pkg.sv | 23 ++
 rtl/Bit_Sync.sv | 22 ++
 rtl/cdc_handshake_tx.sv | 127 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and sizing helpers for the CDC handshake source controller.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERROR  = 2'd3
  } cdc_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 256;

  // Counter width for a given timeout; never narrower than one bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/Bit_Sync.sv
// Two-flop single-bit synchronizer into the CLK domain.
module Bit_Sync (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability time to settle before use.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack multi-bit crossing.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | no word held; ready to accept once the far side has let ack go
//   REQ_HI | word held on tx_data, tx_req high, waiting for ack to rise
//   REQ_LO | tx_req dropped, waiting for ack to fall before the next word
//   ERROR  | far side stopped answering; sticky flag up until err_clr
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  input  logic                  ack_async,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int               TMR_W    = cnt_width(TIMEOUT_CYCLES);
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] CNT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  cdc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  tx_req_d;
  logic                  err_d;
  logic [TMR_W-1:0]      cnt_q, cnt_d;
  logic                  ack_sync;
  logic                  cnt_at_last;

  Bit_Sync u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (ack_async),
    .q   (ack_sync)
  );

  // Expiry only counts when the wait phase is still unsatisfied; the exit
  // test in the FSM is checked first so a coincident ack wins.
  assign cnt_at_last = TMR_EN && (cnt_q == CNT_LAST);

  assign busy = (state_q != IDLE);

  // Next-state, next-output and acceptance decode.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data;
    tx_req_d  = tx_req;
    err_d     = timeout_err;
    src_ready = 1'b0;

    case (state_q)
      IDLE: begin
        src_ready = ~ack_sync;
        if (src_valid && !ack_sync) begin
          tx_data_d = src_data;
          tx_req_d  = 1'b1;
          state_d   = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          tx_req_d = 1'b0;
          state_d  = REQ_LO;
        end else if (cnt_at_last) begin
          tx_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ERROR;
        end
      end
      REQ_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
        end else if (cnt_at_last) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end
      ERROR: begin
        tx_req_d = 1'b0;
        if (err_clr && !ack_sync) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        tx_req_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (TMR_EN && (state_q == REQ_HI || state_q == REQ_LO)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, held word, request level, phase timer and sticky error.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      tx_data     <= '0;
      tx_req      <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_data     <= tx_data_d;
      tx_req      <= tx_req_d;
      timeout_err <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: directed scenarios plus a random phase with an
// auto-responding destination; a negedge monitor scores against queues.
module tb_cdc_handshake_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       ack_async;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  logic auto_ack;
  logic ack_auto;
  logic ack_dir;
  assign ack_async = auto_ack ? ack_auto : ack_dir;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_sent = 0;
  int n_rise = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } acc_t;

  acc_t dq[$];
  int   fq[$];

  cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .ack_async   (ack_async),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Directed ack raise: the tx_req fall is due three edges later.
  task automatic raise_ack();
    ack_dir = 1'b1;
    fq.push_back(cyc + 3);
  endtask

  // Present a word and hold it until accepted; leaves src_valid high.
  task automatic send(input logic [7:0] d);
    int w;
    bit acc;
    src_data  = d;
    src_valid = 1'b1;
    acc = 1'b0;
    w = 0;
    while (!acc && w < 200) begin
      @(negedge CLK);
      acc = src_ready;
      @(posedge CLK);
      #1;
      w++;
    end
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL send_accept: word %0h not accepted in %0d cycles", d, w);
    end else begin
      n_sent++;
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 80) begin
      tick(1);
      w++;
    end
    chk(name, busy, 1'b0);
  endtask

  // Monitor: scores accepts, request rises/falls and per-cycle invariants.
  logic       prev_req = 1'b0;
  logic [7:0] last_data = 8'h00;
  bit         acc_prev = 1'b0;
  always @(negedge CLK) begin
    acc_t e;
    if (!RST) begin
      prev_req  = 1'b0;
      last_data = 8'h00;
      acc_prev  = 1'b0;
    end else begin
      if (tx_req && !prev_req) begin
        n_rise++;
        if (dq.size() == 0) begin
          chk("unexpected_req_rise", 1'b1, 1'b0);
        end else begin
          e = dq.pop_front();
          chk("req_data", tx_data, e.data);
          chk("req_latency", cyc, e.cyc + 1);
        end
      end
      if (!tx_req && prev_req) begin
        if (fq.size() != 0) chk("req_fall_cycle", cyc, fq.pop_front());
        else chk("unacked_fall_needs_err", timeout_err, 1'b1);
      end
      if (!acc_prev) chk("tx_data_stable", tx_data, last_data);
      if (tx_req) chk("ready_low_in_handshake", src_ready, 1'b0);
      if (tx_req || timeout_err) chk("busy_in_handshake", busy, 1'b1);
      acc_prev = src_valid && src_ready;
      if (acc_prev) begin
        e.data = src_data;
        e.cyc  = cyc;
        dq.push_back(e);
      end
      prev_req  = tx_req;
      last_data = tx_data;
    end
  end

  // Destination model: echoes req with a random delay when enabled.
  always begin : responder
    int w;
    @(negedge CLK);
    if (auto_ack && RST && tx_req && !ack_auto) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      @(posedge CLK);
      #1;
      ack_auto = 1'b1;
      fq.push_back(cyc + 3);
      w = 0;
      while (tx_req && w < 60) begin
        @(posedge CLK);
        #1;
        w++;
      end
      if (tx_req) begin
        tests++;
        fails++;
        $display("FAIL resp_req_fall: tx_req still %0b after %0d cycles", tx_req, w);
      end
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      @(posedge CLK);
      #1;
      ack_auto = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; src_data = 8'h00; src_valid = 1'b0; err_clr = 1'b0;
    auto_ack = 1'b0; ack_auto = 1'b0; ack_dir = 1'b0;
    #2;
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_src_ready", src_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    tick(2);
    RST = 1'b1;
    tick(2);

    // Basic transfer with ack echoed three cycles later.
    send(8'hA5);
    src_valid = 1'b0;
    chk("t1_req", tx_req, 1'b1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_ready", src_ready, 1'b0);
    tick(3);
    raise_ack();
    tick(2);
    chk("t1_req_held", tx_req, 1'b1);
    tick(1);
    chk("t1_req_fell", tx_req, 1'b0);
    ack_dir = 1'b0;
    tick(2);
    chk("t1_ready_wait", src_ready, 1'b0);
    chk("t1_busy_wait", busy, 1'b1);
    tick(1);
    chk("t1_ready_back", src_ready, 1'b1);
    chk("t1_idle", busy, 1'b0);

    // Timeout in REQ_HI, then clear.
    send(8'($urandom));
    src_valid = 1'b0;
    tick(15);
    chk("t3_req_before", tx_req, 1'b1);
    chk("t3_err_before", timeout_err, 1'b0);
    tick(1);
    chk("t3_req_after", tx_req, 1'b0);
    chk("t3_err_after", timeout_err, 1'b1);
    chk("t3_ready_err", src_ready, 1'b0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t3_err_clr", timeout_err, 1'b0);
    chk("t3_ready_clr", src_ready, 1'b1);
    chk("t3_idle", busy, 1'b0);

    // Timeout in REQ_LO with ack stuck high; clear only once ack drops.
    send(8'h77);
    src_valid = 1'b0;
    raise_ack();
    tick(18);
    chk("t4_err_before", timeout_err, 1'b0);
    tick(1);
    chk("t4_err_after", timeout_err, 1'b1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_clr_ignored", timeout_err, 1'b1);
    chk("t4_still_busy", busy, 1'b1);
    ack_dir = 1'b0;
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_err_clr", timeout_err, 1'b0);
    chk("t4_ready", src_ready, 1'b1);

    // Ack arrives exactly as the timer reaches its last count.
    send(8'hC3);
    src_valid = 1'b0;
    tick(13);
    raise_ack();
    tick(3);
    chk("t6_req_fell", tx_req, 1'b0);
    chk("t6_no_err", timeout_err, 1'b0);
    chk("t6_busy", busy, 1'b1);
    ack_dir = 1'b0;
    tick(3);
    chk("t6_ready", src_ready, 1'b1);

    // Asynchronous reset in the middle of REQ_HI.
    send(8'h3C);
    src_valid = 1'b0;
    tick(2);
    #1 RST = 1'b0;
    #1;
    chk("t5_req", tx_req, 1'b0);
    chk("t5_data", tx_data, 8'h00);
    chk("t5_ready", src_ready, 1'b1);
    chk("t5_busy", busy, 1'b0);
    @(negedge CLK);
    tick(1);
    RST = 1'b1;
    tick(1);
    send(8'h5A);
    src_valid = 1'b0;
    chk("t5_new_data", tx_data, 8'h5A);
    chk("t5_new_req", tx_req, 1'b1);
    tick(2);
    raise_ack();
    tick(3);
    chk("t5_new_fell", tx_req, 1'b0);
    ack_dir = 1'b0;
    wait_idle("t5_idle");

    // Back-to-back with valid held and an echoing destination.
    auto_ack = 1'b1;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    src_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_queue_empty", dq.size(), 0);

    // Random words with random gaps.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) tick(1);
      send(8'($urandom));
      if ($urandom_range(0, 1) == 0) src_valid = 1'b0;
    end
    src_valid = 1'b0;
    tick(2);
    wait_idle("rand_idle");
    tick(4);
    chk("final_data_queue", dq.size(), 0);
    chk("final_fall_queue", fq.size(), 0);
    chk("final_word_count", n_rise, n_sent);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
